output_scan_reader: RTL
=======================

# output_scan_reader

Host-side read-back engine for the output memory. On a start command it drives the memory's scan port in SCAN_OUT mode, sweeps a contiguous range of 512-bit lines, and serializes each line into 32-bit words on a valid/ready stream toward the testbench or host link. It is the reader for the output memory's scan interface; the controller write packages are unaffected except that functional traffic must be quiesced while `busy` is high.

## Interface
- `DEPTH`, 128: number of output-memory lines; addresses wrap modulo DEPTH.
- `ADDR_W`, 8: scan address width.
- `LINE_W`, 512: memory line width.
- `WORD_W`, 32: stream word width; LINE_W/WORD_W = 16 words per line.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  command strobe, sampled only in IDLE.
- `base_addr`  in  ADDR_W  first line to read, captured with `start`.
- `num_lines`  in  8  line count, captured with `start`; 0 = empty job.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at job end.
- `scan_mode`  out  2  to memory: SCAN_IN=0, LOAD=1, WRITE=2, SCAN_OUT=3.
- `scan_addr`  out  ADDR_W  to memory: line address.
- `scan_out`  in  LINE_W  from memory: read data.
- `word_out`  out  WORD_W  stream data.
- `word_valid`  out  1  stream valid.
- `word_ready`  in  1  stream ready from sink.
- `word_last`  out  1  high with the final word of the job.

## Operation
- States: IDLE, ADDR, CAPTURE, SHIFT, DONE.
- IDLE: `scan_mode`=1 (functional), `busy`=0. On `start`=1: latch `base_addr`, `num_lines`, clear the line counter. If `num_lines`=0, go to DONE; otherwise go to ADDR.
- ADDR: drive `scan_mode`=3 and `scan_addr`=(base+line_cnt) mod DEPTH. Go to CAPTURE.
- CAPTURE: hold the same `scan_mode`/`scan_addr`. Register `scan_out` into the 512-bit line buffer at the clock edge. Clear the word index and go to SHIFT.
- SHIFT: `word_valid`=1, `word_out`=buffer[32*idx +: 32]; word 0 is bits [31:0].
  - `word_out` and `word_last` stay stable until `word_valid && word_ready`.
  - On each handshake, idx increments.
  - On the handshake of idx=15: line_cnt increments. If line_cnt+1 < num_lines, go to ADDR; otherwise go to DONE.
- `word_last` = (idx==15) && (line_cnt==num_lines-1), qualified by `word_valid`.
- DONE: `done`=1 and `busy`=1 for exactly one cycle, `word_valid`=0. Next state is IDLE.
- `scan_mode` stays at 3 throughout ADDR, CAPTURE, SHIFT, and DONE when lines>0. For an empty job, `scan_mode` never leaves 1.
- Addresses wrap: base=126, num_lines=4 reads lines 126, 127, 0, 1. `scan_addr[7]` is always 0 for DEPTH=128. `num_lines` > DEPTH re-reads wrapped lines.
- `start` is ignored outside IDLE.
- Counters are 8-bit (line) and 4-bit (word) with no overflow beyond these rules.

## Timing
- Reset values: `scan_mode`=1, `scan_addr`=0, `word_out`=0, `word_valid`=0, `word_last`=0, `busy`=0, `done`=0. State is IDLE; the latched command and buffer are cleared.
- Memory read latency is one cycle: `scan_out` is valid during the cycle after `scan_addr` is first presented (CAPTURE).
- Cycle timeline, with `start` sampled at edge T:
  - T+1: ADDR.
  - T+2: CAPTURE.
  - T+3: first `word_valid`.
- With `word_ready` held high, each line takes 18 cycles (ADDR + CAPTURE + 16 words).
- Job length for N lines is 18N cycles, then the DONE cycle.
- `done` is asserted in the cycle after the final handshake.
- Back-pressure: `word_ready`=0 stalls SHIFT indefinitely. There is no timeout.
- Reset mid-job (any state): on the next edge all outputs return to reset values. The in-flight line is discarded and no `done` is issued.
- A `start` in the same cycle as `reset` is ignored.

## Test plan
- Single line: preload line 5 with words 0x0000_0000..0x0000_000F (word k = k). Then start base=5, n=1, ready=1.
  - Required: `scan_addr`=5 with `scan_mode`=3 at T+1.
  - Required: words 0..15 on T+3..T+18, `word_last` on 0xF.
  - Required: `done` at T+19, `scan_mode` back to 1 at T+20.
- Wrap: start base=126, n=4.
  - Required: `scan_addr` sequence 126, 127, 0, 1.
  - Required: 64 words, `word_last` only on the 64th.
  - Required: `busy` low after `done`.
- Back-pressure: n=2 with `word_ready` toggling 1,0,0,1,... (random pattern).
  - Required: `word_out` stable while valid && !ready.
  - Required: 32 words in order, none duplicated or dropped.
- Empty job: start n=0.
  - Required: `done` at T+1 with `word_valid`=0 throughout.
  - Required: `scan_mode` stays 1.
- Start while busy: pulse `start` with base=9 mid-job.
  - Required: ignored; the original sequence completes unchanged.
- Reset mid-SHIFT: assert `reset` after word 7 of line 0.
  - Required: next cycle all outputs at reset values.
  - Required: a new start base=0, n=1 then delivers 16 correct words.

Source files
------------

// File: rtl/output_scan_reader.sv
// Host-side read-back engine: sweeps a wrapped range of output-memory lines through
// the SCAN_OUT port and serializes each line into words on a valid/ready stream.
module output_scan_reader #(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LINE_W = 512,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        num_lines,
    output logic              busy,
    output logic              done,
    output logic [1:0]        scan_mode,
    output logic [ADDR_W-1:0] scan_addr,
    input  logic [LINE_W-1:0] scan_out,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              word_last
);

    localparam int unsigned WORDS = LINE_W / WORD_W;
    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam int unsigned SUM_W = ADDR_W + 9;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {SCAN_IN, LOAD, WRITE, SCAN_OUT} scan_mode_e;
    typedef enum logic [2:0] {IDLE, ADDR, CAPTURE, SHIFT, DONE} state_e;

    state_e                         state;
    logic [ADDR_W-1:0]              base_q;
    logic [7:0]                     num_q;
    logic [7:0]                     line_cnt;
    logic [IDX_W-1:0]               idx;
    logic [WORDS-1:0][WORD_W-1:0]   line_buf;

    logic [IDX_W-1:0] next_idx;
    logic             last_line;
    logic             more_lines;

    assign next_idx   = idx + IDX_W'(1);
    assign last_line  = (line_cnt == num_q - 8'd1);
    assign more_lines = ({1'b0, line_cnt} + 9'd1) < {1'b0, num_q};

    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [7:0] cnt);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(cnt);
        return ADDR_W'(sum % SUM_W'(DEPTH));
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            base_q     <= '0;
            num_q      <= '0;
            line_cnt   <= '0;
            idx        <= '0;
            line_buf   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            scan_mode  <= LOAD;
            scan_addr  <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            word_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        num_q    <= num_lines;
                        line_cnt <= '0;
                        busy     <= 1'b1;
                        // Empty job skips the memory entirely so scan_mode never leaves LOAD.
                        if (num_lines == 8'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ADDR;
                            scan_mode <= SCAN_OUT;
                            scan_addr <= wrap_addr(base_addr, 8'd0);
                        end
                    end
                end
                ADDR: state <= CAPTURE;
                CAPTURE: begin
                    line_buf   <= scan_out;
                    idx        <= '0;
                    word_out   <= scan_out[WORD_W-1:0];
                    word_valid <= 1'b1;
                    word_last  <= 1'b0;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    if (word_ready) begin
                        if (idx == LAST_IDX) begin
                            word_valid <= 1'b0;
                            word_last  <= 1'b0;
                            line_cnt   <= line_cnt + 8'd1;
                            if (more_lines) begin
                                state     <= ADDR;
                                scan_addr <= wrap_addr(base_q, line_cnt + 8'd1);
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            idx       <= next_idx;
                            word_out  <= line_buf[next_idx];
                            word_last <= (next_idx == LAST_IDX) && last_line;
                        end
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    scan_mode <= LOAD;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
